frame_reader: RTL and testbench
===============================

FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter WIDTH, default 36, is the sample width in bits (signed).
REQ-002 Parameter DEPTH, default 16, is the number of samples per frame (power of two, >=2).
REQ-003 Parameter ADDR_WIDTH, default $clog2(DEPTH), is the sample index width.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, synchronous and active-low.
REQ-006 buffer_ready_i  in  1  one-cycle pulse: a new frame is available from the ping-pong buffer.
REQ-007 read_data_i  in  WIDTH signed  sample from the buffer.
REQ-008 read_valid_i  in  1  read_data_i is valid.
REQ-009 read_ready_o  out  1  reader accepts a sample this cycle.
REQ-010 result_valid_o  out  1  frame result available.
REQ-011 result_ready_i  in  1  downstream accepts the result.
REQ-012 frame_sum_o  out  WIDTH+ADDR_WIDTH signed  sum of the frame's samples.
REQ-013 frame_peak_o  out  WIDTH unsigned  maximum |sample| in the frame.
REQ-014 sample_count_o  out  ADDR_WIDTH+1  samples accepted in the current frame.
REQ-015 overrun_o  out  1  one-cycle pulse: a frame was aborted or dropped.
REQ-016 dropped_count_o  out  8  saturating count of aborted or dropped frames.
REQ-017 busy_o  out  1  high when the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, DRAIN and RESULT.
REQ-019 A sample is accepted in a cycle where read_valid_i and read_ready_o are both high; read_data_i is captured in that same cycle.
REQ-020 read_ready_o SHALL be high only in DRAIN, and is a registered state decode.
REQ-021 IDLE: on buffer_ready_i, go to DRAIN next cycle; clear sum, peak and count.
REQ-022 DRAIN: per accepted sample, sum += sign-extended sample, peak = max(peak, |sample|), and count += 1.
REQ-023 |sample| SHALL be computed in WIDTH bits unsigned; -2^(WIDTH-1) gives 2^(WIDTH-1) with no wrap.
REQ-024 On acceptance of sample number DEPTH, the update SHALL include that sample; go to RESULT next cycle.
REQ-025 DRAIN with buffer_ready_i high (a frame swap before drain completes): abort the frame.
  - clear accumulators and count; stay in DRAIN.
  - discard any sample accepted that same cycle.
  - pulse overrun_o; increment dropped_count_o.
REQ-026 read_valid_i low during DRAIN SHALL stall with no timeout; accumulators hold.
REQ-027 RESULT: result_valid_o=1.
  - frame_sum_o, frame_peak_o and sample_count_o (=DEPTH) SHALL hold stable until result_ready_i is high.
REQ-028 RESULT with buffer_ready_i: set a pending flag.
  - If the flag is already set, pulse overrun_o and increment dropped_count_o instead.
REQ-029 Result handshake (result_valid_o and result_ready_i): clear result_valid_o next cycle.
  - pending flag set, or buffer_ready_i in the same cycle: go to DRAIN with accumulators cleared and the flag cleared.
  - otherwise: go to IDLE.
REQ-030 dropped_count_o SHALL saturate at 255.
REQ-031 frame_sum_o width SHALL guarantee no overflow for DEPTH full-scale samples.
REQ-032 sample_count_o SHALL reflect the live count in DRAIN and the frozen count in RESULT.

Reset
REQ-033 While rst_ni=0 at a clock edge, the block SHALL go to IDLE and clear all outputs and internal registers to 0, including the pending flag.
REQ-034 Reset mid-DRAIN or mid-RESULT SHALL discard the partial frame with no overrun_o pulse; the first buffer_ready_i after reset starts a fresh frame.

Verification (WIDTH=36, DEPTH=16)
REQ-035 Pulse buffer_ready_i, then feed samples 1..16 with read_valid_i held high -> RESULT with frame_sum_o=136, frame_peak_o=16, sample_count_o=16; read_ready_o low one cycle after the 16th accept.
REQ-036 Feed 16 samples of -2^35 -> frame_sum_o=-2^39, frame_peak_o=2^35, no overflow.
REQ-037 Pulse buffer_ready_i after the 7th sample -> overrun_o pulse, dropped_count_o=1; the next 16 samples of value 3 give frame_sum_o=48.
REQ-038 Hold result_ready_i low for 10 cycles and pulse buffer_ready_i twice in RESULT.
  - outputs stable; one overrun_o pulse, dropped_count_o=1.
  - after the handshake, the FSM enters DRAIN directly.
REQ-039 Toggle read_valid_i randomly (~50%) -> same sum/peak as a gap-free frame.
REQ-040 Assert rst_ni=0 for one cycle after the 5th sample -> all outputs 0, state IDLE, no overrun_o pulse; the next frame computes correctly.

Source files
------------

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - drains one ping-pong buffer frame per buffer_ready_i and reports its sum, peak |sample| and count
module frame_reader #(
  parameter int WIDTH      = 36,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                buffer_ready_i,
  input  logic signed [WIDTH-1:0]             read_data_i,
  input  logic                                read_valid_i,
  output logic                                read_ready_o,
  output logic                                result_valid_o,
  input  logic                                result_ready_i,
  output logic signed [WIDTH+ADDR_WIDTH-1:0]  frame_sum_o,
  output logic [WIDTH-1:0]                    frame_peak_o,
  output logic [ADDR_WIDTH:0]                 sample_count_o,
  output logic                                overrun_o,
  output logic [7:0]                          dropped_count_o,
  output logic                                busy_o
);

  typedef enum logic [1:0] {IDLE, DRAIN, RESULT} state_t;

  localparam int SUM_W = WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH+1)'(1);

  state_t state_q, state_d;
  logic   ready_q;
  logic   pending_q;

  logic                    accept;
  logic                    handshake;
  logic                    last_sample;
  logic                    clear_acc;
  logic                    drop_event;
  logic [WIDTH-1:0]        sample_abs;
  logic signed [SUM_W-1:0] sample_ext;

  assign accept      = read_valid_i & read_ready_o;
  assign handshake   = result_valid_o & result_ready_i;
  assign last_sample = (sample_count_o == LAST_IDX);

  // Unsigned negate keeps the most negative sample exact (2^(WIDTH-1) fits in WIDTH bits).
  assign sample_abs = read_data_i[WIDTH-1] ? (~$unsigned(read_data_i) + WIDTH'(1))
                                           : $unsigned(read_data_i);
  assign sample_ext = {{ADDR_WIDTH{read_data_i[WIDTH-1]}}, read_data_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == DRAIN);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (buffer_ready_i) state_d = DRAIN;
      DRAIN:   if (!buffer_ready_i && accept && last_sample) state_d = RESULT;
      RESULT:  if (handshake) state_d = (pending_q || buffer_ready_i) ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_ready_o   = ready_q;
    result_valid_o = (state_q == RESULT);
    busy_o         = (state_q != IDLE);
    clear_acc      = 1'b0;
    drop_event     = 1'b0;
    unique case (state_q)
      IDLE: clear_acc = buffer_ready_i;
      DRAIN: begin
        clear_acc  = buffer_ready_i;
        drop_event = buffer_ready_i;
      end
      RESULT: begin
        clear_acc  = handshake && (pending_q || buffer_ready_i);
        drop_event = !handshake && buffer_ready_i && pending_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frame_sum_o     <= '0;
      frame_peak_o    <= '0;
      sample_count_o  <= '0;
      pending_q       <= 1'b0;
      overrun_o       <= 1'b0;
      dropped_count_o <= '0;
    end else begin
      overrun_o <= drop_event;
      if (drop_event && dropped_count_o != 8'hFF)
        dropped_count_o <= dropped_count_o + 8'd1;

      // An abort takes priority over a sample accepted in the same cycle.
      if (clear_acc) begin
        frame_sum_o    <= '0;
        frame_peak_o   <= '0;
        sample_count_o <= '0;
      end else if (state_q == DRAIN && accept) begin
        frame_sum_o    <= frame_sum_o + sample_ext;
        sample_count_o <= sample_count_o + COUNT_ONE;
        if (sample_abs > frame_peak_o)
          frame_peak_o <= sample_abs;
      end

      if (state_q == RESULT) begin
        if (handshake)
          pending_q <= 1'b0;
        else if (buffer_ready_i)
          pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - scoreboard bench for frame_reader with WIDTH=36, DEPTH=16
module tb_frame_reader;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               buffer_ready_i = 1'b0;
  logic signed [35:0] read_data_i = '0;
  logic               read_valid_i = 1'b0;
  logic               read_ready_o;
  logic               result_valid_o;
  logic               result_ready_i = 1'b0;
  logic signed [39:0] frame_sum_o;
  logic [35:0]        frame_peak_o;
  logic [4:0]         sample_count_o;
  logic               overrun_o;
  logic [7:0]         dropped_count_o;
  logic               busy_o;

  typedef struct {
    logic signed [39:0] sum;
    logic [35:0]        peak;
    logic [4:0]         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ovr_seen = 0;
  int   ovr0;

  frame_reader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .buffer_ready_i(buffer_ready_i),
    .read_data_i(read_data_i), .read_valid_i(read_valid_i), .read_ready_o(read_ready_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .frame_sum_o(frame_sum_o), .frame_peak_o(frame_peak_o), .sample_count_o(sample_count_o),
    .overrun_o(overrun_o), .dropped_count_o(dropped_count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every RESULT cycle must match the oldest expected frame; pop on handshake.
  always @(negedge clk_i) begin
    if (overrun_o) ovr_seen++;
    if (result_valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        check("result_sum", frame_sum_o, exp_q[0].sum);
        check("result_peak", frame_peak_o, exp_q[0].peak);
        check("result_count", sample_count_o, exp_q[0].cnt);
        if (result_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic signed [39:0] s, input logic [35:0] p);
    exp_t e;
    e.sum = s; e.peak = p; e.cnt = 5'd16;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_br();
    buffer_ready_i = 1'b1;
    step();
    buffer_ready_i = 1'b0;
  endtask

  task automatic send(input logic signed [35:0] v, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        read_valid_i = 1'b0;
        step();
      end
    end
    read_data_i  = v;
    read_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!read_ready_o && n < 100);
    if (!read_ready_o) check("accept_timeout", 64'd0, 64'd1);
    step();
    read_valid_i = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_ready"}, read_ready_o, 0);
    check({tag, "_valid"}, result_valid_o, 0);
    check({tag, "_sum"}, frame_sum_o, 0);
    check({tag, "_peak"}, frame_peak_o, 0);
    check({tag, "_count"}, sample_count_o, 0);
    check({tag, "_dropped"}, dropped_count_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle_zero("reset");
    step();

    // Samples 1..16, gap-free.
    result_ready_i = 1'b1;
    push_exp(40'sd136, 36'd16);
    pulse_br();
    for (int i = 1; i <= 16; i++) send(36'(i), 1'b0);
    check("ready_low_after_last", read_ready_o, 0);
    check("valid_after_last", result_valid_o, 1);
    step();
    @(negedge clk_i);
    check("idle_after_handshake", busy_o, 0);
    step();

    // Full-scale negative samples.
    push_exp(-40'sh80_0000_0000, 36'h8_0000_0000);
    pulse_br();
    for (int i = 0; i < 16; i++) send(36'sh8_0000_0000, 1'b0);
    step(); step();

    // Abort after the 7th sample, with a discarded sample on the abort cycle.
    ovr0 = ovr_seen;
    pulse_br();
    for (int i = 0; i < 7; i++) send(36'sd5, 1'b0);
    buffer_ready_i = 1'b1; read_data_i = 36'sd100; read_valid_i = 1'b1;
    step();
    buffer_ready_i = 1'b0; read_valid_i = 1'b0;
    step();
    check("abort_overrun_pulses", ovr_seen - ovr0, 1);
    check("abort_overrun_one_cycle", overrun_o, 0);
    check("abort_dropped", dropped_count_o, 1);
    check("abort_count_cleared", sample_count_o, 0);
    check("abort_stays_drain", read_ready_o, 1);
    push_exp(40'sd48, 36'd3);
    for (int i = 0; i < 16; i++) send(36'sd3, 1'b0);
    step(); step();

    // Result held 10 cycles with two buffer_ready_i pulses.
    result_ready_i = 1'b0;
    push_exp(40'sd32, 36'd2);
    pulse_br();
    for (int i = 0; i < 16; i++) send(36'sd2, 1'b0);
    ovr0 = ovr_seen;
    step(); step();
    pulse_br();
    step(); step();
    pulse_br();
    repeat (4) step();
    check("hold_overrun_pulses", ovr_seen - ovr0, 1);
    check("hold_dropped", dropped_count_o, 2);
    push_exp(40'sd8, 36'd16);
    result_ready_i = 1'b1;
    step();
    check("direct_drain_busy", busy_o, 1);
    check("direct_drain_ready", read_ready_o, 1);
    check("direct_drain_valid", result_valid_o, 0);
    check("direct_drain_count", sample_count_o, 0);

    // Alternating-sign frame with random valid gaps: -1+2-3+...+16 = 8.
    for (int i = 1; i <= 16; i++) send((i % 2) ? -36'(i) : 36'(i), 1'b1);
    step(); step();

    // Reset after the 5th sample.
    ovr0 = ovr_seen;
    pulse_br();
    for (int i = 0; i < 5; i++) send(36'sd7, 1'b0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle_zero("midreset");
    step();
    check("midreset_no_overrun", ovr_seen - ovr0, 0);
    push_exp(40'sd136, 36'd16);
    pulse_br();
    for (int i = 1; i <= 16; i++) send(36'(i), 1'b0);
    step(); step();

    // Dropped counter saturation: 260 consecutive aborts.
    ovr0 = ovr_seen;
    pulse_br();
    buffer_ready_i = 1'b1;
    repeat (260) step();
    buffer_ready_i = 1'b0;
    step();
    check("sat_overrun_pulses", ovr_seen - ovr0, 260);
    check("sat_dropped", dropped_count_o, 255);

    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
